// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_frame_pkg;

    localparam logic [7:0] HEADER     = 8'hAA;
    localparam logic [7:0] ACK        = 8'h55;
    localparam logic [7:0] NAK        = 8'hEE;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_DATA      = 3'd2,
        ST_EXEC      = 3'd3,
        ST_TX_STAT   = 3'd4,
        ST_WAIT_STAT = 3'd5,
        ST_TX_DATA   = 3'd6,
        ST_WAIT_DATA = 3'd7
    } frame_state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle timer: counts enabled cycles, flags expiry on the last count.
// Latency: expire is combinational from the count, high in the cycle count == TIMEOUT_CYCLES-1.
// Backpressure: none; clr has priority over en and suppresses expire.
// Ports: clk, rst_ni (async active-low), clr (restart at 0), en (count this cycle),
//        expire (one-cycle flag while enabled at the terminal count).
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 86800
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A clear in the same cycle means a byte arrived; the byte wins over expiry.
    assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses AA/cmd/data host frames, executes register read/write, sends status (+read data) over UART TX.
// Latency: data byte at t -> EXEC t+1 -> tx_start_o at t+2; read data tx_start_o the cycle after tx_done_i.
// Backpressure: none upstream; RX bytes arriving while a frame executes or responds are dropped and counted.
// Ports: clk, rst_ni; rx_valid_i/rx_data_i from the receiver; tx_start_o/tx_data_o/tx_done_i to the
//        transmitter; regs_o register bank (reg k at [8k+7:8k]); frame_active_o; err_cnt_o saturating errors.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 86800
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_done_i,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  frame_active_o,
    output logic [7:0]            err_cnt_o
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    frame_state_t state_q, state_d;

    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] cmd_q;
    logic [7:0] data_q;
    logic [7:0] tx_data_q;
    logic [7:0] rd_q;
    logic       rd_ok_q;
    logic [7:0] err_q;

    logic       in_hdr_wait;
    logic       expire;
    logic       addr_ok;
    logic       is_write;
    logic       rx_drop;
    logic       err_inc;

    // Timer only runs while waiting for cmd/data bytes; any other state holds it at zero,
    // so entering CMD always starts from a fresh count.
    assign in_hdr_wait = (state_q == ST_CMD) || (state_q == ST_DATA);

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_ni (rst_ni),
        .clr    (rx_valid_i || !in_hdr_wait),
        .en     (in_hdr_wait),
        .expire (expire)
    );

    assign addr_ok  = ({1'b0, cmd_q[6:0]} < 8'(NUM_REGS));
    assign is_write = cmd_q[CMD_WR_BIT];

    // Bytes cannot be accepted once the frame is complete until the response is fully sent.
    assign rx_drop = rx_valid_i && !(state_q == ST_IDLE || in_hdr_wait);
    assign err_inc = rx_drop || (expire && !rx_valid_i) ||
                     ((state_q == ST_EXEC) && !addr_ok);

    always_comb begin
        state_d        = state_q;
        tx_start_o     = 1'b0;
        frame_active_o = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && rx_data_i == HEADER) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid_i)  state_d = ST_DATA;
                else if (expire) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_valid_i)  state_d = ST_EXEC;
                else if (expire) state_d = ST_IDLE;
            end
            ST_EXEC: begin
                state_d = ST_TX_STAT;
            end
            ST_TX_STAT: begin
                tx_start_o = 1'b1;
                state_d    = ST_WAIT_STAT;
            end
            ST_WAIT_STAT: begin
                if (tx_done_i) state_d = rd_ok_q ? ST_TX_DATA : ST_IDLE;
            end
            ST_TX_DATA: begin
                tx_start_o = 1'b1;
                state_d    = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (tx_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            tx_data_q <= '0;
            rd_q      <= '0;
            rd_ok_q   <= 1'b0;
        end else begin
            if (state_q == ST_CMD && rx_valid_i)  cmd_q  <= rx_data_i;
            if (state_q == ST_DATA && rx_valid_i) data_q <= rx_data_i;

            if (state_q == ST_EXEC) begin
                // tx_data_q is loaded here so the status byte is already stable when TX_STAT pulses.
                tx_data_q <= addr_ok ? ACK : NAK;
                rd_ok_q   <= addr_ok && !is_write;
                if (addr_ok) begin
                    if (is_write) regs_q[cmd_q[AW-1:0]] <= data_q;
                    else          rd_q                  <= regs_q[cmd_q[AW-1:0]];
                end
            end

            if (state_q == ST_WAIT_STAT && tx_done_i && rd_ok_q) tx_data_q <= rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[8*k +: 8] = regs_q[k];
    end

    assign tx_data_o = tx_data_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a behavioural transmitter that answers tx_start_o.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_frame_ctrl;
    // Shortened timeout keeps the run small; the expiry boundary is checked cycle-exactly.
    localparam int TB_TIMEOUT = 200;
    localparam int TX_GAP     = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i = 1'b0;
    logic [31:0] regs_o;
    logic        frame_active_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_log [$];

    uart_frame_ctrl #(
        .NUM_REGS       (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .rx_valid_i     (rx_valid_i),
        .rx_data_i      (rx_data_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .tx_done_i      (tx_done_i),
        .regs_o         (regs_o),
        .frame_active_o (frame_active_o),
        .err_cnt_o      (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: logs each started byte, checks it is held, then pulses done.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_start_o && rst_ni) begin
                b = tx_data_o;
                tx_log.push_back(b);
                repeat (TX_GAP) @(posedge clk);
                #1;
                if (rst_ni) chk("tx_hold", {24'h0, tx_data_o}, {24'h0, b});
                tx_done_i = 1'b1;
                @(posedge clk);
                #1 tx_done_i = 1'b0;
            end
        end
    end

    // Returns #1 after the edge that samples the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid_i = 1'b1;
        rx_data_i = b;
        @(posedge clk);
        #1 rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] d);
        send_byte(h);
        repeat (2) @(posedge clk);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (frame_active_o && n < 500) begin
            @(posedge clk);
            #1 n++;
        end
        repeat (2) @(posedge clk);
        #1 chk(tag, {31'h0, frame_active_o}, 32'h0);
    endtask

    task automatic chk_tx(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
        chk({tag, "_n"}, tx_log.size(), n);
        if (tx_log.size() > 0) chk({tag, "_b0"}, {24'h0, tx_log[0]}, {24'h0, b0});
        if (n > 1 && tx_log.size() > 1) chk({tag, "_b1"}, {24'h0, tx_log[1]}, {24'h0, b1});
        tx_log.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regs", regs_o, 32'h0);
        chk("rst_start", {31'h0, tx_start_o}, 32'h0);
        chk("rst_txdata", {24'h0, tx_data_o}, 32'h0);
        chk("rst_err", {24'h0, err_cnt_o}, 32'h0);
        chk("rst_active", {31'h0, frame_active_o}, 32'h0);
        rst_ni = 1'b1;

        // Write reg1 = 3C; visible with the status start two cycles after the data byte.
        send_byte(8'hAA);
        chk("hdr_active", {31'h0, frame_active_o}, 32'h1);
        send_byte(8'h81);
        send_byte(8'h3C);
        chk("wr_not_yet", regs_o, 32'h0);
        @(posedge clk);
        #1;
        chk("wr_regs", regs_o, 32'h0000_3C00);
        chk("wr_start", {31'h0, tx_start_o}, 32'h1);
        chk("wr_stat", {24'h0, tx_data_o}, 32'h55);
        wait_idle("wr_idle");
        chk_tx("wr_tx", 1, 8'h55, 8'h00);
        chk("wr_err", {24'h0, err_cnt_o}, 32'h0);

        // Read reg1 back.
        send_frame(8'hAA, 8'h01, 8'h00);
        wait_idle("rd_idle");
        chk_tx("rd_tx", 2, 8'h55, 8'h3C);
        chk("rd_regs", regs_o, 32'h0000_3C00);

        // Write to out-of-range address 5.
        send_frame(8'hAA, 8'h85, 8'h12);
        wait_idle("bad_idle");
        chk_tx("bad_tx", 1, 8'hEE, 8'h00);
        chk("bad_regs", regs_o, 32'h0000_3C00);
        chk("bad_err", {24'h0, err_cnt_o}, 32'h1);

        // Leading garbage is discarded silently.
        send_byte(8'h16);
        chk("garb_idle", {31'h0, frame_active_o}, 32'h0);
        send_byte(8'h0B);
        send_frame(8'hAA, 8'h80, 8'h7F);
        wait_idle("garb_done");
        chk_tx("garb_tx", 1, 8'h55, 8'h00);
        chk("garb_regs", regs_o, 32'h0000_3C7F);
        chk("garb_err", {24'h0, err_cnt_o}, 32'h1);

        // Timeout in DATA: still active after TIMEOUT-1 idle cycles, idle one cycle later.
        send_byte(8'hAA);
        send_byte(8'h81);
        repeat (TB_TIMEOUT - 1) @(posedge clk);
        #1 chk("to_edge_active", {31'h0, frame_active_o}, 32'h1);
        @(posedge clk);
        #1;
        chk("to_idle", {31'h0, frame_active_o}, 32'h0);
        chk("to_err", {24'h0, err_cnt_o}, 32'h2);
        chk("to_regs", regs_o, 32'h0000_3C7F);
        send_frame(8'hAA, 8'h02, 8'h00);
        wait_idle("to_rd_idle");
        chk_tx("to_rd_tx", 2, 8'h55, 8'h00);

        // Byte injected while waiting for the status to finish is dropped.
        send_frame(8'hAA, 8'h83, 8'h99);
        repeat (2) @(posedge clk);
        send_byte(8'h42);
        wait_idle("drop_idle");
        chk_tx("drop_tx", 1, 8'h55, 8'h00);
        chk("drop_err", {24'h0, err_cnt_o}, 32'h3);
        chk("drop_regs", regs_o, 32'h9900_3C7F);

        // Asynchronous reset in DATA clears everything immediately.
        send_byte(8'hAA);
        send_byte(8'h80);
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_regs", regs_o, 32'h0);
        chk("arst_err", {24'h0, err_cnt_o}, 32'h0);
        chk("arst_active", {31'h0, frame_active_o}, 32'h0);
        chk("arst_txdata", {24'h0, tx_data_o}, 32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        send_frame(8'hAA, 8'h81, 8'h5A);
        wait_idle("post_idle");
        chk_tx("post_tx", 1, 8'h55, 8'h00);
        chk("post_regs", regs_o, 32'h0000_5A00);
        chk("post_err", {24'h0, err_cnt_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
